// File: rtl/pulse_checker.sv
// Receive-side checker for a periodic single-cycle pulse train: measures the
// interval between pulses, locks after LOCK_CNT good intervals, flags early/missing pulses.
module pulse_checker #(
    parameter int PULSE    = 5,
    parameter int LOCK_CNT = 3,
    parameter int ERR_W    = 8,
    parameter int PER_W    = $clog2(PULSE + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             signal,
    output logic             locked,
    output logic             err_early,
    output logic             err_miss,
    output logic [PER_W-1:0] period,
    output logic [ERR_W-1:0] err_count
);

    localparam int GW = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);
    localparam logic [PER_W-1:0] LAST = PER_W'(PULSE - 1);
    localparam logic [PER_W-1:0] FULL = PER_W'(PULSE);

    typedef enum logic [1:0] {IDLE, ACQ, LOCKED} state_t;

    state_t           state_q, state_d;
    logic [PER_W-1:0] cnt_q, cnt_d;
    logic [GW-1:0]    good_q, good_d;
    logic             locked_q, locked_d;
    logic             early_q, early_d;
    logic             miss_q, miss_d;
    logic [PER_W-1:0] period_q, period_d;
    logic [ERR_W-1:0] errc_q, errc_d;

    logic active, is_good, is_early, is_miss;

    always_comb begin
        active   = (state_q != IDLE);
        is_good  = signal && (cnt_q == LAST);
        is_early = signal && (cnt_q < LAST);
        is_miss  = !signal && (cnt_q == LAST);

        state_d  = state_q;
        good_d   = good_q;
        early_d  = 1'b0;
        miss_d   = 1'b0;
        period_d = period_q;
        errc_d   = errc_q;

        if (signal)
            cnt_d = '0;
        else if (cnt_q == FULL)
            cnt_d = cnt_q;
        else
            cnt_d = cnt_q + PER_W'(1);

        case (state_q)
            IDLE: begin
                if (signal) begin
                    state_d = ACQ;
                    good_d  = '0;
                end
            end
            ACQ: begin
                if (is_good) begin
                    good_d = good_q + GW'(1);
                    if ((good_q + GW'(1)) == GW'(LOCK_CNT))
                        state_d = LOCKED;
                end else if (is_early) begin
                    good_d = '0;
                end else if (is_miss) begin
                    state_d = IDLE;
                    good_d  = '0;
                end
            end
            LOCKED: begin
                if (is_early) begin
                    state_d = ACQ;
                    good_d  = '0;
                end else if (is_miss) begin
                    state_d = IDLE;
                    good_d  = '0;
                end
            end
            default: begin
                state_d = IDLE;
                good_d  = '0;
            end
        endcase

        // Measurement and error flags only apply once a pulse train has been seen.
        if (active) begin
            if (signal)
                period_d = cnt_q + PER_W'(1);
            early_d = is_early;
            miss_d  = is_miss;
            if ((is_early || is_miss) && (errc_q != '1))
                errc_d = errc_q + ERR_W'(1);
        end

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            good_q   <= '0;
            locked_q <= 1'b0;
            early_q  <= 1'b0;
            miss_q   <= 1'b0;
            period_q <= '0;
            errc_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            good_q   <= good_d;
            locked_q <= locked_d;
            early_q  <= early_d;
            miss_q   <= miss_d;
            period_q <= period_d;
            errc_q   <= errc_d;
        end
    end

    assign locked    = locked_q;
    assign err_early = early_q;
    assign err_miss  = miss_q;
    assign period    = period_q;
    assign err_count = errc_q;

endmodule

// File: tb/tb_pulse_checker.sv
// Directed bench for pulse_checker: default instance plus ERR_W=2 and LOCK_CNT=1 variants
// sharing one stimulus stream.
module tb_pulse_checker;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       signal = 1'b0;

    logic       a_locked, a_early, a_miss;
    logic [2:0] a_period;
    logic [7:0] a_errc;
    logic       b_locked, b_early, b_miss;
    logic [2:0] b_period;
    logic [1:0] b_errc;
    logic       c_locked, c_early, c_miss;
    logic [2:0] c_period;
    logic [7:0] c_errc;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pulse_checker #(.PULSE(5), .LOCK_CNT(3), .ERR_W(8)) dut_a (
        .clk(clk), .reset_n(reset_n), .signal(signal), .locked(a_locked),
        .err_early(a_early), .err_miss(a_miss), .period(a_period), .err_count(a_errc)
    );

    pulse_checker #(.PULSE(5), .LOCK_CNT(3), .ERR_W(2)) dut_b (
        .clk(clk), .reset_n(reset_n), .signal(signal), .locked(b_locked),
        .err_early(b_early), .err_miss(b_miss), .period(b_period), .err_count(b_errc)
    );

    pulse_checker #(.PULSE(5), .LOCK_CNT(1), .ERR_W(8)) dut_c (
        .clk(clk), .reset_n(reset_n), .signal(signal), .locked(c_locked),
        .err_early(c_early), .err_miss(c_miss), .period(c_period), .err_count(c_errc)
    );

    // Drive one sample, let the edge take it, then look at the registered result.
    task automatic cyc(input logic s);
        signal = s;
        @(posedge clk);
        #1;
    endtask

    task automatic gap(input int unsigned k);
        repeat (k - 1) cyc(1'b0);
        cyc(1'b1);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        cyc(1'b0);
        cyc(1'b1);
        checks++;
        if ({a_locked, a_early, a_miss} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: got %b, expected 000", {a_locked, a_early, a_miss});
        end
        checks++;
        if (a_period !== 3'd0) begin
            errors++; $display("FAIL reset_period: got %0d, expected 0", a_period);
        end
        checks++;
        if (a_errc !== 8'd0 || b_errc !== 2'd0) begin
            errors++; $display("FAIL reset_errc: got %0d/%0d, expected 0/0", a_errc, b_errc);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_lock();
        cyc(1'b1);
        checks++;
        if ({a_locked, a_early, a_miss, a_period} !== 6'd0) begin
            errors++; $display("FAIL first_pulse: got lk=%b e=%b m=%b per=%0d, expected all 0",
                               a_locked, a_early, a_miss, a_period);
        end
        for (int p = 2; p <= 4; p++) begin
            repeat (4) begin
                cyc(1'b0);
                checks++;
                if ({a_early, a_miss} !== 2'b00) begin
                    errors++; $display("FAIL lock_gap_flags: got %b, expected 00", {a_early, a_miss});
                end
            end
            cyc(1'b1);
            checks++;
            if (a_locked !== (p == 4)) begin
                errors++; $display("FAIL lock_pulse%0d: got locked=%b, expected %b", p, a_locked, (p == 4));
            end
            checks++;
            if (a_period !== 3'd5) begin
                errors++; $display("FAIL lock_period: got %0d, expected 5", a_period);
            end
            if (p == 2) begin
                checks++;
                if (c_locked !== 1'b1) begin
                    errors++; $display("FAIL lockcnt1: got locked=%b, expected 1", c_locked);
                end
            end
        end
        checks++;
        if ({a_early, a_miss, a_errc} !== 10'd0) begin
            errors++; $display("FAIL lock_noerr: got e=%b m=%b cnt=%0d, expected 0", a_early, a_miss, a_errc);
        end
    endtask

    task automatic test_early();
        gap(3);
        checks++;
        if ({a_locked, a_early, a_miss} !== 3'b010) begin
            errors++; $display("FAIL early_flags: got %b, expected 010", {a_locked, a_early, a_miss});
        end
        checks++;
        if (a_period !== 3'd3 || a_errc !== 8'd1) begin
            errors++; $display("FAIL early_meas: got per=%0d cnt=%0d, expected 3/1", a_period, a_errc);
        end
        cyc(1'b0);
        checks++;
        if (a_early !== 1'b0) begin
            errors++; $display("FAIL early_one_cycle: got %b, expected 0", a_early);
        end
        repeat (3) cyc(1'b0);
        cyc(1'b1);
        for (int g = 2; g <= 3; g++) begin
            checks++;
            if (a_locked !== 1'b0) begin
                errors++; $display("FAIL relock_early: got %b, expected 0", a_locked);
            end
            gap(5);
        end
        checks++;
        if ({a_locked, a_early, a_miss} !== 3'b100 || a_errc !== 8'd1) begin
            errors++; $display("FAIL relock: got flags=%b cnt=%0d, expected 100/1", {a_locked, a_early, a_miss}, a_errc);
        end
    endtask

    task automatic test_miss();
        repeat (4) cyc(1'b0);
        checks++;
        if ({a_locked, a_miss} !== 2'b10) begin
            errors++; $display("FAIL miss_before: got %b, expected 10", {a_locked, a_miss});
        end
        cyc(1'b0);
        checks++;
        if ({a_locked, a_early, a_miss} !== 3'b001 || a_errc !== 8'd2) begin
            errors++; $display("FAIL miss_flag: got flags=%b cnt=%0d, expected 001/2", {a_locked, a_early, a_miss}, a_errc);
        end
        cyc(1'b0);
        checks++;
        if (a_miss !== 1'b0) begin
            errors++; $display("FAIL miss_one_cycle: got %b, expected 0", a_miss);
        end
        repeat (3) cyc(1'b0);
        checks++;
        if ({a_miss, a_errc} !== {1'b0, 8'd2}) begin
            errors++; $display("FAIL idle_quiet: got m=%b cnt=%0d, expected 0/2", a_miss, a_errc);
        end
        cyc(1'b1);
        checks++;
        if ({a_locked, a_early} !== 2'b00 || a_period !== 3'd5 || a_errc !== 8'd2) begin
            errors++; $display("FAIL reentry: got lk=%b e=%b per=%0d cnt=%0d, expected 0/0/5/2",
                               a_locked, a_early, a_period, a_errc);
        end
        gap(3);
        checks++;
        if (a_early !== 1'b1 || a_period !== 3'd3 || a_errc !== 8'd3) begin
            errors++; $display("FAIL reentry_acq: got e=%b per=%0d cnt=%0d, expected 1/3/3", a_early, a_period, a_errc);
        end
    endtask

    task automatic test_hold_high();
        reset_n = 1'b0;
        cyc(1'b0);
        reset_n = 1'b1;
        cyc(1'b1);
        checks++;
        if (a_early !== 1'b0 || a_period !== 3'd0) begin
            errors++; $display("FAIL hold_first: got e=%b per=%0d, expected 0/0", a_early, a_period);
        end
        for (int i = 1; i <= 9; i++) begin
            cyc(1'b1);
            checks++;
            if ({a_early, a_miss} !== 2'b10 || a_errc !== 8'(i)) begin
                errors++; $display("FAIL hold_early%0d: got e=%b m=%b cnt=%0d, expected 1/0/%0d",
                                   i, a_early, a_miss, a_errc, i);
            end
            checks++;
            if (b_errc !== ((i > 3) ? 2'd3 : 2'(i))) begin
                errors++; $display("FAIL sat_errc%0d: got %0d, expected %0d", i, b_errc, (i > 3) ? 3 : i);
            end
        end
        checks++;
        if (a_period !== 3'd1) begin
            errors++; $display("FAIL hold_period: got %0d, expected 1", a_period);
        end
        repeat (4) cyc(1'b0);
        checks++;
        if ({a_early, a_miss} !== 2'b00) begin
            errors++; $display("FAIL hold_release: got %b, expected 00", {a_early, a_miss});
        end
        cyc(1'b0);
        checks++;
        if (a_miss !== 1'b1 || a_errc !== 8'd10 || b_errc !== 2'd3) begin
            errors++; $display("FAIL hold_miss: got m=%b cnt=%0d sat=%0d, expected 1/10/3", a_miss, a_errc, b_errc);
        end
    endtask

    task automatic test_reset_mid_lock();
        cyc(1'b1);
        repeat (3) gap(5);
        checks++;
        if (a_locked !== 1'b1 || a_errc !== 8'd10) begin
            errors++; $display("FAIL prelock: got lk=%b cnt=%0d, expected 1/10", a_locked, a_errc);
        end
        repeat (4) cyc(1'b0);
        reset_n = 1'b0;
        cyc(1'b1);
        reset_n = 1'b1;
        checks++;
        if ({a_locked, a_early, a_miss, a_period, a_errc} !== 14'd0) begin
            errors++; $display("FAIL midreset: got lk=%b e=%b m=%b per=%0d cnt=%0d, expected all 0",
                               a_locked, a_early, a_miss, a_period, a_errc);
        end
        cyc(1'b0);
        checks++;
        if (a_locked !== 1'b0) begin
            errors++; $display("FAIL midreset_after: got %b, expected 0", a_locked);
        end
        cyc(1'b0);
        cyc(1'b1);
        checks++;
        if (a_early !== 1'b0 || a_period !== 3'd0) begin
            errors++; $display("FAIL midreset_idle: got e=%b per=%0d, expected 0/0", a_early, a_period);
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_early();
        test_miss();
        test_hold_high();
        test_reset_mid_lock();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
